stride_window_buffer: RTL
=========================

Name: stride_window_buffer

Overview:
Width-converting circular buffer feeding the multiplier array of the convolution accelerator. It accepts wide write sets of WR_WORDS words. It presents read windows of RD_WORDS consecutive words. The read pointer advances by a runtime stride, so overlapping windows can be reused for sliding-kernel convolution. It sits between the input-feature loader and the MAC array, and replaces the fixed non-overlapping set buffer.

Parameters:
DATA_WIDTH, 32, bits per word
BUFFER_SIZE, 1024, storage depth in words; power of 2; integer multiple of WR_WORDS
WR_WORDS, 128, words accepted per write (one set)
RD_WORDS, 16, words presented per read window (one per multiplier); RD_WORDS <= BUFFER_SIZE

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
clr  input  1  synchronous flush: empties buffer, keeps config
wen  input  1  write request
din  input  WR_WORDS*DATA_WIDTH  write set; word 0 in LSBs
ren  input  1  read request
rd_stride  input  $clog2(RD_WORDS)+1  words consumed per accepted read
full_flag  output  1  free space < WR_WORDS
empty_flag  output  1  occupancy < RD_WORDS
dout  output  RD_WORDS*DATA_WIDTH  read window; word 0 = oldest word, in LSBs
dout_valid  output  1  dout holds a new window this cycle
count  output  $clog2(BUFFER_SIZE)+1  current occupancy in words

Behaviour:
- Reset (rst=1): wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_valid=0, full_flag=0, empty_flag=1. rst has priority over clr, wen and ren. Storage contents are not cleared.
- clr=1 (rst=0): same pointer, count and flag result as reset. dout is held and dout_valid=0. wen and ren in the same cycle are ignored.
- Flags are combinational from registered count only, with no lookahead.
  - full_flag = (BUFFER_SIZE - count) < WR_WORDS.
  - empty_flag = count < RD_WORDS.
- Write accept: wr_acc = wen & ~full_flag. On accept, din word i is stored at (wr_ptr+i) mod BUFFER_SIZE, and wr_ptr advances by WR_WORDS mod BUFFER_SIZE. A write while full is dropped with no state change.
- Read accept: rd_acc = ren & ~empty_flag.
  - Next cycle: dout word j = mem[(rd_ptr+j) mod BUFFER_SIZE] for j=0..RD_WORDS-1, and dout_valid=1. Latency is 1 cycle.
  - rd_ptr advances by s mod BUFFER_SIZE.
  - s = rd_stride if 1 <= rd_stride <= RD_WORDS; otherwise s = RD_WORDS.
  - A read while empty is ignored: dout is held and dout_valid=0 next cycle.
- Count update: count_next = count + (wr_acc ? WR_WORDS : 0) - (rd_acc ? s : 0).
- Simultaneous wr_acc and rd_acc are legal. Both are evaluated against the pre-cycle count.
  - A write while full is still dropped even if a read is accepted in the same cycle.
  - A read never observes words written in the same cycle.
- Window wrap: a window or write set straddling BUFFER_SIZE-1 → 0 wraps word-by-word.
- Overlap: with s < RD_WORDS, the last RD_WORDS-s words of one window are the first words of the next.
- Tail: fewer than RD_WORDS remaining words cannot be read. Upstream pads the stream or issues clr.
- dout_valid is a single-cycle pulse per accepted read. dout holds its value between reads.

Optional Feature:
Macro STRIDE_BUFFER_ERR_FLAG_EN.
- Defined: adds outputs ovf_err and udf_err, both 1 bit.
  - ovf_err is set on a dropped write (wen & full_flag). udf_err is set on an ignored read (ren & empty_flag).
  - Both are sticky until rst or clr, and reset to 0.
- Not defined: the ports do not exist, and dropped or ignored requests are silent. All other behaviour is identical.

Test Plan:
- Reset, then one write of words 0..127 → count=128, empty_flag=0, full_flag=0. ren with rd_stride=16 → next cycle dout_valid=1, dout=words 0..15, count=112.
- Overlap: after 128 written, three reads with rd_stride=4 → windows 0..15, 4..19, 8..23; count=116.
- Fill: 8 writes → count=1024, full_flag=1. A 9th wen is dropped: count stays 1024, and ovf_err=1 when the macro is defined.
- Wrap: write 8 sets and read 63×16 with stride 16 → count=16, rd_ptr=1008. Then write one set and read with stride 16 → dout=words 1008..1023. The next read returns the first 16 words of the new set at addresses 0..15.
- Simultaneous: count=16 with ren+wen (stride 16) → window returned, write accepted, count=128. With count=1024, ren+wen → write dropped, count=1008.
- Edge strides and flush: rd_stride=0 and rd_stride=31 each consume 16 words. With count=10, ren → no dout_valid, and udf_err=1 when the macro is defined. clr asserted with wen → count=0, empty_flag=1, write ignored.

Source files
------------

// File: rtl/stride_window_buffer.sv
// Circular word buffer: accepts WR_WORDS-word sets and presents RD_WORDS-word windows with a runtime stride.
// Optional sticky overflow/underflow error outputs when STRIDE_BUFFER_ERR_FLAG_EN is defined.
module stride_window_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int BUFFER_SIZE = 1024,
    parameter int WR_WORDS    = 128,
    parameter int RD_WORDS    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           wen,
    input  logic [WR_WORDS*DATA_WIDTH-1:0] din,
    input  logic                           ren,
    input  logic [$clog2(RD_WORDS):0]      rd_stride,
    output logic                           full_flag,
    output logic                           empty_flag,
    output logic [RD_WORDS*DATA_WIDTH-1:0] dout,
    output logic                           dout_valid,
`ifdef STRIDE_BUFFER_ERR_FLAG_EN
    output logic                           ovf_err,
    output logic                           udf_err,
`endif
    output logic [$clog2(BUFFER_SIZE):0]   count
);
    localparam int PW = $clog2(BUFFER_SIZE);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(RD_WORDS) + 1;

    logic [DATA_WIDTH-1:0]          mem [BUFFER_SIZE];
    logic [PW-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                  count_q, count_d;
    logic [RD_WORDS*DATA_WIDTH-1:0] dout_q, dout_d, window;
    logic                           dout_valid_q, dout_valid_d;
    logic                           wr_acc, rd_acc;
    logic [SW-1:0]                  stride_eff;

    assign full_flag  = (CW'(BUFFER_SIZE) - count_q) < CW'(WR_WORDS);
    assign empty_flag = count_q < CW'(RD_WORDS);
    assign wr_acc     = wen && !full_flag && !clr;
    assign rd_acc     = ren && !empty_flag && !clr;

    // Out-of-range strides (0 or > RD_WORDS) fall back to non-overlapping windows.
    always_comb begin
        stride_eff = SW'(RD_WORDS);
        if (rd_stride != '0 && rd_stride <= SW'(RD_WORDS)) begin
            stride_eff = rd_stride;
        end
    end

    always_comb begin
        window = '0;
        for (int j = 0; j < RD_WORDS; j++) begin
            window[j*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr_q + PW'(j)];
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PW'(WR_WORDS);
            end
            if (rd_acc) begin
                rd_ptr_d     = rd_ptr_q + PW'(stride_eff);
                dout_d       = window;
                dout_valid_d = 1'b1;
            end
            count_d = count_q + (wr_acc ? CW'(WR_WORDS) : CW'(0))
                              - (rd_acc ? CW'(stride_eff) : CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Storage has no reset; a read window is captured from the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            for (int i = 0; i < WR_WORDS; i++) begin
                mem[wr_ptr_q + PW'(i)] <= din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef STRIDE_BUFFER_ERR_FLAG_EN
    logic ovf_err_q, udf_err_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            if (wen && full_flag) begin
                ovf_err_q <= 1'b1;
            end
            if (ren && empty_flag) begin
                udf_err_q <= 1'b1;
            end
        end
    end

    assign ovf_err = ovf_err_q;
    assign udf_err = udf_err_q;
`endif

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign count      = count_q;
endmodule
